// File: rtl/am_sample_fifo.sv
// rtl/am_sample_fifo.sv - first-word-fall-through sample buffer with prefill gate for the AM modulator
module am_sample_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int PREFILL      = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  empty,
    input  logic                  read,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_flags
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PREFILL_L = (ADDR_WIDTH+1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0]   AFULL_L   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   LEVEL_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic {FILLING, STREAMING} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     level_next;
    logic                    wr_acc;
    logic                    rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = read && !empty;

    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc)
            level_next = level + LEVEL_ONE;
        else if (!wr_acc && rd_acc)
            level_next = level - LEVEL_ONE;
    end

    // Storage is deliberately left unreset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_next;
        end
    end

    // A clear in the same cycle as a set event leaves the flag low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear_flags) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            if (read && empty)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILLING;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILLING:   if (level_next >= PREFILL_L) state_next = STREAMING;
            STREAMING: if (level_next == '0)        state_next = FILLING;
            default:   state_next = FILLING;
        endcase
    end

    always_comb begin
        empty       = (state == FILLING) || (level == '0);
        full        = (level == DEPTH_L);
        almost_full = (level >= AFULL_L);
    end

    assign sample = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_am_sample_fifo.sv
// tb/tb_am_sample_fifo.sv - directed self-checking bench for am_sample_fifo
module tb_am_sample_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       almost_full;
    logic [7:0] sample;
    logic       empty;
    logic       read;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;
    logic       clear_flags;

    int checks = 0;
    int failures = 0;

    am_sample_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .PREFILL(8),
        .AFULL_THRESH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .almost_full(almost_full),
        .sample(sample),
        .empty(empty),
        .read(read),
        .level(level),
        .overflow(overflow),
        .underflow(underflow),
        .clear_flags(clear_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_data = '0;
        wr_en = 1'b0;
        read = 1'b0;
        clear_flags = 1'b0;
        @(negedge clk);

        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_sample", sample, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b0;

        // Prefill: seven words keep the gate closed
        for (int i = 1; i <= 7; i++) begin
            write_word(8'(i));
            chk("prefill_empty", empty, 1);
            chk("prefill_sample", sample, 0);
        end
        chk("prefill_level7", level, 7);
        write_word(8'h08);
        chk("release_empty", empty, 0);
        chk("release_sample", sample, 8'h01);
        chk("release_level", level, 8);

        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", sample, i);
            pop();
        end
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);
        chk("drain_sample", sample, 0);
        chk("drain_unf", underflow, 0);

        // Refill after drain, read during FILLING is refused
        for (int i = 0; i < 3; i++) write_word(8'(8'h21 + i));
        pop();
        chk("fill_read_unf", underflow, 1);
        chk("fill_read_level", level, 3);
        chk("fill_read_empty", empty, 1);
        for (int i = 3; i < 7; i++) write_word(8'(8'h21 + i));
        chk("refill7_empty", empty, 1);
        write_word(8'h28);
        chk("refill8_empty", empty, 0);
        chk("refill8_sample", sample, 8'h21);
        pulse_clear();
        chk("clear_unf", underflow, 0);
        for (int i = 0; i < 8; i++) begin
            chk("refill_head", sample, 8'h21 + i);
            pop();
        end
        chk("refill_drained", empty, 1);

        // Fill to capacity plus one dropped word
        for (int k = 1; k <= 16; k++) begin
            write_word(8'(8'h3F + k));
            chk("fill_level", level, k);
            chk("fill_afull", almost_full, (k >= 12) ? 1 : 0);
            chk("fill_full", full, (k == 16) ? 1 : 0);
            chk("fill_ovf", overflow, 0);
        end
        write_word(8'h50);
        chk("ovf_level", level, 16);
        chk("ovf_set", overflow, 1);
        chk("ovf_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            chk("full_readback", sample, 8'h40 + i);
            pop();
        end
        chk("full_drained", empty, 1);
        chk("full_drained_sample", sample, 0);
        pulse_clear();
        chk("clear_ovf", overflow, 0);

        // Steady state at level 10 with simultaneous write and pop
        for (int i = 0; i < 10; i++) write_word(8'(8'h60 + i));
        chk("steady_level", level, 10);
        chk("steady_head", sample, 8'h60);
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h6A + i);
            read    = 1'b1;
            #1;
            chk("steady_sample", sample, 8'h60 + i);
            chk("steady_lvl", level, 10);
            @(negedge clk);
        end
        wr_en = 1'b0;
        read  = 1'b0;
        chk("steady_end_level", level, 10);
        chk("steady_end_head", sample, 8'h74);
        chk("steady_ovf", overflow, 0);
        chk("steady_unf", underflow, 0);
        for (int i = 0; i < 5; i++) pop();
        chk("pre_rst_level", level, 5);
        chk("pre_rst_head", sample, 8'h79);

        // Asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1;
        chk("async_empty", empty, 1);
        chk("async_level", level, 0);
        chk("async_sample", sample, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            write_word(8'(8'h90 + i));
            chk("post_rst_empty", empty, 1);
        end
        write_word(8'h97);
        chk("post_rst_release", empty, 0);
        chk("post_rst_sample", sample, 8'h90);
        chk("post_rst_level", level, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
